// File: rtl/gmii_frame_gen.sv
// gmii_frame_gen: GMII test-frame generator; define GMII_FRAME_GEN_CRC_EN to append the FCS
`timescale 1ns/1ps
module gmii_frame_gen #(
  parameter int PAYLOAD_LEN = 46,
  parameter int IFG_CYCLES = 12,
  parameter logic [47:0] DST_MAC = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC = 48'h00_0A_35_01_FE_C0,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        gmii_tx_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  speed_selection,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETHERTYPE};
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, FCS, IFG} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, cnt_nx, len;
  logic phase, phase_nx, gig, gig_nx, tx_act, step, last, frame_done;
  logic [7:0] tx_byte, txd_nx;
  logic [6:0] hpos;
`ifdef GMII_FRAME_GEN_CRC_EN
  logic [31:0] crc, crc_nx, fcs_word;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
`endif
  // next-state, byte selection and next output values; one byte per clock (gigabit) or per two clocks (nibble)
  always_comb begin
    len = 16'd1;
    tx_byte = 8'h00;
    state_nx = state;
    hpos = {4'd13 - cnt[3:0], 3'b000};
    tx_act = state != IDLE && state != IFG;
    step = state == IFG || (tx_act && (gig || phase));
`ifdef GMII_FRAME_GEN_CRC_EN
    fcs_word = ~crc;
`endif
    case (state)
      PREAMBLE: begin len = 16'd7; tx_byte = 8'h55; end
      SFD:      begin len = 16'd1; tx_byte = 8'hD5; end
      HEADER:   begin len = 16'd14; tx_byte = HDR[hpos +: 8]; end
      PAYLOAD:  begin
        len = 16'(PAYLOAD_LEN);
        tx_byte = cnt == 16'd0 ? frame_cnt[15:8] : cnt == 16'd1 ? frame_cnt[7:0] : cnt[7:0];
      end
`ifdef GMII_FRAME_GEN_CRC_EN
      FCS:      begin len = 16'd4; tx_byte = fcs_word[{cnt[1:0], 3'b000} +: 8]; end
`endif
      IFG:      len = 16'(IFG_CYCLES);
      default: ;
    endcase
    last = step && cnt == len - 16'd1;
    case (state)
      IDLE:     state_nx = ((start && !busy) || continuous) ? PREAMBLE : IDLE;
      PREAMBLE: state_nx = last ? SFD : state;
      SFD:      state_nx = last ? HEADER : state;
      HEADER:   state_nx = last ? PAYLOAD : state;
`ifdef GMII_FRAME_GEN_CRC_EN
      PAYLOAD:  state_nx = last ? FCS : state;
      FCS:      state_nx = last ? IFG : state;
`else
      PAYLOAD:  state_nx = last ? IFG : state;
`endif
      IFG:      state_nx = last ? (continuous ? PREAMBLE : IDLE) : state;
      default:  state_nx = IDLE;
    endcase
    cnt_nx = last ? 16'd0 : step ? cnt + 16'd1 : cnt;
    phase_nx = tx_act && !gig && !phase;
    gig_nx = (state == IDLE && state_nx == PREAMBLE) ? speed_selection == 2'b10 : gig;
    txd_nx = !tx_act ? 8'h00 : gig ? tx_byte : {4'h0, phase ? tx_byte[7:4] : tx_byte[3:0]};
`ifdef GMII_FRAME_GEN_CRC_EN
    frame_done = last && state == FCS;
    crc_nx = (state == IDLE || state_nx == PREAMBLE) ? 32'hFFFF_FFFF :
             (step && (state == HEADER || state == PAYLOAD)) ? crc_byte(crc, tx_byte) : crc;
`else
    frame_done = last && state == PAYLOAD;
`endif
  end
  // state and registered outputs; reset truncates any frame in flight
  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 16'd0;
      phase <= 1'b0;
      gig <= 1'b1;
      gmii_txd <= 8'h00;
      gmii_tx_en <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= 16'd0;
`ifdef GMII_FRAME_GEN_CRC_EN
      crc <= 32'hFFFF_FFFF;
`endif
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      phase <= phase_nx;
      gig <= gig_nx;
      gmii_txd <= txd_nx;
      gmii_tx_en <= tx_act;
      busy <= state != IDLE;
      frame_cnt <= frame_done ? frame_cnt + 16'd1 : frame_cnt;
`ifdef GMII_FRAME_GEN_CRC_EN
      crc <= crc_nx;
`endif
    end
  end
endmodule

// File: tb/tb_gmii_frame_gen.sv
// tb_gmii_frame_gen: scoreboard bench for gmii_frame_gen (gigabit, nibble, continuous, reset, ignored start)
`timescale 1ns/1ps
module tb_gmii_frame_gen;
  localparam int PL = 46;
  localparam int IFG = 12;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0;
  logic [1:0] speed = 2'b10;
  logic [7:0] txd;
  logic tx_en, busy;
  logic [15:0] frame_cnt;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  int len_q[$];
  bit chk_gap = 1'b0;
  int run = 0, gap = 0, pos = 0, starts = 0;
  bit in_fr = 1'b0, seen = 1'b0, half = 1'b0;
  logic [3:0] lo = 4'h0;
  logic [31:0] rcrc = 32'hFFFF_FFFF;

  gmii_frame_gen dut (
    .gmii_tx_clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .speed_selection(speed), .gmii_txd(txd), .gmii_tx_en(tx_en), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [15:0] seq, input bit nb);
    logic [7:0] f[$];
    logic [111:0] hdr;
`ifdef GMII_FRAME_GEN_CRC_EN
    logic [31:0] c;
`endif
    hdr = {48'hFFFF_FFFF_FFFF, 48'h000A_3501_FEC0, 16'h88B5};
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    for (int i = 0; i < 14; i++) f.push_back(hdr[111-8*i -: 8]);
    for (int i = 0; i < PL; i++) f.push_back(i == 0 ? seq[15:8] : i == 1 ? seq[7:0] : 8'(i));
`ifdef GMII_FRAME_GEN_CRC_EN
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < f.size(); i++) c = crc8(c, f[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
`endif
    foreach (f[i]) begin
      if (nb) begin
        exp_q.push_back({4'h0, f[i][3:0]});
        exp_q.push_back({4'h0, f[i][7:4]});
      end else exp_q.push_back(f[i]);
    end
    len_q.push_back(nb ? 2 * f.size() : f.size());
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while ((busy || tx_en || exp_q.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL timeout_done waited=%0d pending=%0d", n, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_low(input int maxc);
    int n = 0;
    while (tx_en && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL timeout_txen_low waited=%0d", n);
    end
  endtask

  task automatic wait_starts(input int k, input int maxc);
    int n = 0;
    while (starts < k && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL timeout_starts seen=%0d required=%0d", starts, k);
    end
  endtask

  // monitor: pops expected bytes, checks frame length, gaps, idle data and CRC residue
  always @(negedge clk) begin
    if (reset) begin
      run = 0; gap = 0; pos = 0; starts = 0;
      in_fr = 1'b0; seen = 1'b0; half = 1'b0;
      rcrc = 32'hFFFF_FFFF;
    end else if (tx_en) begin
      if (!in_fr) begin
        if (chk_gap && seen) chk("ifg_gap", gap, IFG);
        in_fr = 1'b1;
        starts++;
      end
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_txd actual=%0h required=none", txd);
      end else chk("txd", txd, exp_q.pop_front());
      run++;
      if (speed != 2'b10) begin
        if (half) begin
          if (pos >= 8) rcrc = crc8(rcrc, {txd[3:0], lo});
          pos++;
        end else lo = txd[3:0];
        half = !half;
      end else begin
        if (pos >= 8) rcrc = crc8(rcrc, txd);
        pos++;
      end
    end else begin
      chk("txd_idle", txd, 8'h00);
      if (in_fr) begin
        if (len_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame actual_len=%0d required=none", run);
        end else chk("frame_len", run, len_q.pop_front());
`ifdef GMII_FRAME_GEN_CRC_EN
        chk("crc_residue", bitrev(rcrc), 32'hC704DD7B);
`endif
        in_fr = 1'b0; seen = 1'b1; run = 0; gap = 0; pos = 0; half = 1'b0;
        rcrc = 32'hFFFF_FFFF;
      end
      gap++;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 8'h00);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    push_frame(16'h0000, 1'b0);
    pulse_start();
    @(negedge clk);
    chk("lat_tx_en_early", tx_en, 1'b0);
    chk("lat_busy_early", busy, 1'b0);
    @(negedge clk);
    chk("lat_tx_en", tx_en, 1'b1);
    chk("lat_busy", busy, 1'b1);
    repeat (7) @(posedge clk);
    pulse_start();
    wait_low(200);
    repeat (3) @(posedge clk);
    #1 chk("busy_ifg", busy, 1'b1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(300);
    chk("cnt_single", frame_cnt, 16'd1);
    speed = 2'b01;
    push_frame(16'h0001, 1'b1);
    pulse_start();
    wait_done(600);
    chk("cnt_nibble", frame_cnt, 16'd2);
    speed = 2'b10;
    push_frame(16'h0002, 1'b0);
    pulse_start();
    repeat (20) @(posedge clk);
    #2 exp_q.delete();
    len_q.delete();
    reset = 1'b1;
    #1 chk("mid_rst_txd", txd, 8'h00);
    chk("mid_rst_tx_en", tx_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    push_frame(16'h0000, 1'b0);
    push_frame(16'h0001, 1'b0);
    push_frame(16'h0002, 1'b0);
    chk_gap = 1'b1;
    continuous = 1'b1;
    wait_starts(3, 600);
    continuous = 1'b0;
    wait_done(600);
    chk_gap = 1'b0;
    chk("cnt_continuous", frame_cnt, 16'd3);
    chk("frames_continuous", starts, 3);
    chk("frames_pending", len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
